// File: rtl/reverse_bits.sv
// reverse_bits: two-lane bit permutation unit with a one-cycle registered
// result. Each accepted input is transformed according to mode:
//   00 full bit reversal, 01 pass-through, 10 half swap, 11 inverted reversal.
// Both lanes (a->q, b->w) use the same mode and are otherwise independent.
//
// Handshake: in_valid is sampled on each rising clk edge; there is no
// back-pressure, so every edge with in_valid=1 is accepted and produces
// out_valid=1 for exactly the following cycle along with its q/w result.
// Edges with in_valid=0 keep q/w unchanged and drive out_valid low.
//
// Optional feature: define REVERSE_BITS_PARITY_EN to add q_par/w_par, the
// even-parity (XOR reduction) of the registered q and w.
//
// WIDTH must be an even integer >= 2 so the half swap is well defined.
module reverse_bits #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] w,
  output logic             out_valid
`ifdef REVERSE_BITS_PARITY_EN
  ,
  output logic             q_par,
  output logic             w_par
`endif
);

  localparam int HALF = WIDTH / 2;

  localparam logic [1:0] MODE_REVERSE = 2'b00;
  localparam logic [1:0] MODE_PASS    = 2'b01;
  localparam logic [1:0] MODE_SWAP    = 2'b10;
  localparam logic [1:0] MODE_INV_REV = 2'b11;

  // Per-lane transform shared by both lanes so they cannot diverge.
  function automatic logic [WIDTH-1:0] f_lane(input logic [1:0]       m,
                                              input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] rev;
    logic [WIDTH-1:0] res;
    for (int i = 0; i < WIDTH; i++) begin
      rev[WIDTH-1-i] = d[i];
    end
    case (m)
      MODE_REVERSE: res = rev;
      MODE_PASS:    res = d;
      MODE_SWAP:    res = {d[HALF-1:0], d[WIDTH-1:HALF]};
      MODE_INV_REV: res = ~rev;
      default:      res = d;
    endcase
    return res;
  endfunction

  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_w_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_w;
  logic             r_valid;

  // Combinational transform of the current operands for both lanes.
  always_comb begin
    w_q_next = f_lane(mode, a);
    w_w_next = f_lane(mode, b);
  end

  // Result registers: load on accepted input, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      r_w <= '0;
    end else if (in_valid) begin
      r_q <= w_q_next;
      r_w <= w_w_next;
    end
  end

  // Output strobe: one cycle high per accepted input, back-to-back capable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
    end
  end

  assign q         = r_q;
  assign w         = r_w;
  assign out_valid = r_valid;

`ifdef REVERSE_BITS_PARITY_EN
  // Parity follows the registered results, so it updates on the same edge
  // and reads 0 while q/w are reset to 0.
  assign q_par = ^r_q;
  assign w_par = ^r_w;
`endif

endmodule

// File: tb/tb_reverse_bits.sv
// Self-checking bench for reverse_bits (WIDTH=8): directed cases, async
// reset, mid-cycle input changes, and a randomized stream scored against a
// behavioural model. Parity checks are active when REVERSE_BITS_PARITY_EN
// is defined.
module tb_reverse_bits;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [1:0]   mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] q;
  logic [W-1:0] w;
  logic         out_valid;
`ifdef REVERSE_BITS_PARITY_EN
  logic         q_par;
  logic         w_par;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [2*W-1:0] exp_q[$];   // {expected q, expected w}
  logic [W-1:0]   last_q;
  logic [W-1:0]   last_w;

  reverse_bits #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .q         (q),
    .w         (w),
    .out_valid (out_valid)
`ifdef REVERSE_BITS_PARITY_EN
    ,
    .q_par     (q_par),
    .w_par     (w_par)
`endif
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "watchdog expired");
  end

  // Checker
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h wanted 0x%0h", tag, got, want);
    end
  endtask

  // Reference model, from the mode rules with plain arithmetic
  function automatic logic [W-1:0] model(input logic [1:0] m, input logic [W-1:0] x);
    int v;
    int r;
    int h;
    v = int'(x);
    r = 0;
    h = W / 2;
    for (int i = 0; i < W; i++) r = (r * 2) + ((v >> i) & 1);
    case (m)
      2'd0:    model = W'(r);
      2'd1:    model = x;
      2'd2:    model = W'((v >> h) + ((v % (1 << h)) << h));
      default: model = W'((1 << W) - 1 - r);
    endcase
  endfunction

  function automatic logic parity(input logic [W-1:0] x);
    int c;
    c = 0;
    for (int i = 0; i < W; i++) c += (int'(x) >> i) & 1;
    return logic'(c % 2);
  endfunction

  // Scoreboard step after each edge
  task automatic check_outputs(input logic v);
    logic [2*W-1:0] e;
    chk("out_valid", 32'(out_valid), 32'(v));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        last_q = e[2*W-1:W];
        last_w = e[W-1:0];
      end
    end
    chk(out_valid ? "q" : "q_hold", 32'(q), 32'(last_q));
    chk(out_valid ? "w" : "w_hold", 32'(w), 32'(last_w));
`ifdef REVERSE_BITS_PARITY_EN
    chk("q_par", 32'(q_par), 32'(parity(last_q)));
    chk("w_par", 32'(w_par), 32'(parity(last_w)));
`endif
  endtask

  // Driver: one clock cycle of stimulus followed by a check
  task automatic drive(input logic v, input logic [1:0] m, input logic [W-1:0] da, input logic [W-1:0] db);
    @(negedge clk);
    in_valid = v;
    mode     = m;
    a        = da;
    b        = db;
    if (v) exp_q.push_back({model(m, da), model(m, db)});
    @(posedge clk);
    #1;
    check_outputs(v);
  endtask

  // Inputs wiggle mid-cycle; registered outputs must not move
  task automatic glitch_inputs();
    #2;
    a        = W'($urandom);
    b        = W'($urandom);
    mode     = 2'($urandom_range(0, 3));
    in_valid = 1'($urandom_range(0, 1));
    #1;
    chk("mid_q", 32'(q), 32'(last_q));
    chk("mid_w", 32'(w), 32'(last_w));
  endtask

  // Asynchronous reset pulse placed between edges
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_w", 32'(w), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    a        = W'($urandom);
    b        = W'($urandom);
    @(posedge clk);
    #1;
    chk("rst_hold_valid", 32'(out_valid), 32'd0);
    chk("rst_hold_q", 32'(q), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    exp_q.delete();
    last_q = '0;
    last_w = '0;
  endtask

  // Main sequence
  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    mode     = 2'b00;
    a        = '0;
    b        = '0;
    last_q   = '0;
    last_w   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_q", 32'(q), 32'd0);
    chk("init_w", 32'(w), 32'd0);
    chk("init_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: reversal, then idle hold
    drive(1'b1, 2'b00, 8'h01, 8'hA5);
    chk("dir_q_80", 32'(q), 32'h80);
    chk("dir_w_a5", 32'(w), 32'hA5);
    drive(1'b0, 2'b00, 8'h33, 8'h44);
    glitch_inputs();

    // Palindromes, then nibble patterns
    drive(1'b1, 2'b00, 8'h24, 8'h81);
    chk("pal_q", 32'(q), 32'h24);
    chk("pal_w", 32'(w), 32'h81);
    drive(1'b1, 2'b00, 8'hF0, 8'h0E);
    chk("nib_q", 32'(q), 32'h0F);
    chk("nib_w", 32'(w), 32'h70);

    // Mode sweep
    drive(1'b1, 2'b01, 8'h12, 8'h12);
    chk("sweep01", 32'(q), 32'h12);
    drive(1'b1, 2'b10, 8'h12, 8'h12);
    chk("sweep10", 32'(q), 32'h21);
    drive(1'b1, 2'b11, 8'h12, 8'h12);
    chk("sweep11", 32'(q), 32'hB7);
    drive(1'b0, 2'b00, 8'h00, 8'h00);

`ifdef REVERSE_BITS_PARITY_EN
    drive(1'b1, 2'b00, 8'h07, 8'h03);
    chk("par_q_dir", 32'(q_par), 32'd1);
    chk("par_w_dir", 32'(w_par), 32'd0);
`endif

    // Back-to-back random stream, mode 00
    for (int i = 0; i < 12; i++) drive(1'b1, 2'b00, W'($urandom), W'($urandom));

    // Reset in the middle of a stream, then resume
    drive(1'b1, 2'b00, W'($urandom), W'($urandom));
    async_reset();
    drive(1'b1, 2'b00, 8'h01, 8'h02);
    chk("post_rst_q", 32'(q), 32'h80);
    chk("post_rst_w", 32'(w), 32'h40);

    // Randomized mixed traffic
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
      if ($urandom_range(0, 9) == 0) glitch_inputs();
    end

    drive(1'b0, 2'b00, 8'h00, 8'h00);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reverse_bits.md
REVERSE_BITS -- requirements
Module: reverse_bits

Interface
REQ-001 Parameter WIDTH, default 8, data width of each lane; SHALL be an even integer >= 2.
REQ-002 clk  input  1  rising-edge clock; the block's single clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  high marks a and b as valid this cycle.
REQ-005 mode  input  2  operation select, sampled with in_valid.
REQ-006 a  input  WIDTH  lane-A operand.
REQ-007 b  input  WIDTH  lane-B operand.
REQ-008 q  output  WIDTH  lane-A result, registered.
REQ-009 w  output  WIDTH  lane-B result, registered.
REQ-010 out_valid  output  1  high for exactly one cycle per accepted input.
REQ-011 q_par, w_par  output  1 each  even-parity bits of q and w; present only when REVERSE_BITS_PARITY_EN is defined.

Function
REQ-012 The block SHALL accept an input on each rising clk edge where in_valid=1, with no back-pressure; throughput is one operation per cycle.
REQ-013 mode=00: full bit reversal, q[WIDTH-1-i]=a[i] and w[WIDTH-1-i]=b[i] for all i.
REQ-014 mode=01: pass-through, q=a, w=b.
REQ-015 mode=10: half swap, upper and lower WIDTH/2 halves exchanged, bit order within each half preserved.
REQ-016 mode=11: inverted reversal, bitwise NOT of the mode-00 result.
REQ-017 Lanes A and B SHALL be processed identically and independently with the same mode.
REQ-018 Latency SHALL be exactly one cycle: q, w and out_valid update on the edge that samples in_valid=1.
REQ-019 When in_valid=0 at an edge, q and w SHALL hold their previous values and out_valid SHALL be 0.
REQ-020 Back-to-back valid inputs SHALL produce back-to-back out_valid pulses, each with its own result; no input is dropped.
REQ-021 Inputs SHALL be sampled only at the clock edge; changes between edges have no effect on the outputs.

Reset
REQ-022 rst_n=0 SHALL asynchronously force q=0, w=0 and out_valid=0 (and q_par=0, w_par=0 when present), independent of clk.
REQ-023 While rst_n=0, in_valid SHALL be ignored.
REQ-024 Reset asserted mid-stream SHALL discard the in-flight result; the first edge after rst_n deasserts with in_valid=1 produces a normal result one cycle later.

Configuration
REQ-025 Macro REVERSE_BITS_PARITY_EN defined: the block SHALL provide q_par and w_par.
REQ-026 q_par and w_par SHALL be the XOR reduction of the registered q and w respectively, and update on the same edge as q and w.
REQ-027 Macro REVERSE_BITS_PARITY_EN undefined: the q_par and w_par ports and their logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-028 Reset: rst_n=0 pulsed asynchronously between edges -> q=0x00, w=0x00 and out_valid=0 immediately.
REQ-029 mode=00, a=0x01, b=0xA5, in_valid=1 -> next edge q=0x80, w=0xA5, out_valid=1; following idle cycle out_valid=0 and q/w held.
REQ-030 mode=00, a=0x24, b=0x81 -> q=0x24, w=0x81 (palindromes). Then a=0xF0, b=0x0E -> q=0x0F, w=0x70.
REQ-031 mode sweep with a=0x12: 01 -> q=0x12; 10 -> q=0x21; 11 -> q=0xB7.
REQ-032 Random stream: 8+ consecutive cycles of random a/b with in_valid=1, mode=00 -> each q/w equals the bit-reversed input of the previous cycle; out_valid stays high throughout.
REQ-033 REVERSE_BITS_PARITY_EN defined, mode=00, a=0x07, b=0x03 -> q_par=1, w_par=0; build without the macro compiles with no parity ports.
